// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipeline.
//   Takes the registered ID/EX fields, applies operand forwarding, runs a
//   single-cycle ALU or an iterative unsigned MULT into HI/LO, and registers
//   the EX/MEM fields. While a multi-cycle op runs, stall holds PC, IF/ID and
//   ID/EX, and EX/MEM receives bubbles.
//
// Build option:
//   EX_DIVIDER_EN  when defined, aluOp 4'b1011 is an iterative restoring DIVU
//                  (LO = quotient, HI = remainder); otherwise 4'b1011 is an
//                  unknown code (result 0, no stall).
//
// Ports:
//   clock, reset          clock; synchronous active-high reset
//   aluOp, regDst, aluSrc ID/EX control fields
//   WB, M                 write-back / memory controls, passed through
//   rs, rt, rd            register numbers (rs is consumed by the forwarding unit upstream)
//   pcPlus4               passed through to exMemPcPlus4
//   data1, data2          register file read data
//   immediate             sign-extended immediate
//   fwdA, fwdB            00/11 regfile, 01 memWbResult, 10 exMemResult
//   exMemResult           forwarded EX/MEM result
//   memWbResult           forwarded MEM/WB result
//   stall                 combinational pipeline hold
//   exMem*                registered EX/MEM fields
//
// state | meaning
// IDLE  | accepting instructions; a MULT/DIVU here latches operands and stalls
// MUL   | one shift-add step per cycle, stalled, bubbles into EX/MEM
// DIV   | one restoring-divide step per cycle (divider builds only)
// DONE  | stall released; the MULT/DIVU still in ID/EX retires as a bubble

module ex_stage #(
    parameter int DATA_W  = 32,
    parameter int MUL_CYC = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        aluOp,
    input  logic              regDst,
    input  logic              aluSrc,
    input  logic [1:0]        WB,
    input  logic [2:0]        M,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [DATA_W-1:0] pcPlus4,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] immediate,
    input  logic [1:0]        fwdA,
    input  logic [1:0]        fwdB,
    input  logic [DATA_W-1:0] exMemResult,
    input  logic [DATA_W-1:0] memWbResult,
    output logic              stall,
    output logic [1:0]        exMemWB,
    output logic [2:0]        exMemM,
    output logic [DATA_W-1:0] exMemAluResult,
    output logic [DATA_W-1:0] exMemStoreData,
    output logic [4:0]        exMemWriteReg,
    output logic              exMemZero,
    output logic [DATA_W-1:0] exMemPcPlus4
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_MFHI = 4'b1001;
    localparam logic [3:0] OP_MFLO = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;
`ifdef EX_DIVIDER_EN
    localparam logic [3:0] OP_DIVU = 4'b1011;
`endif

    localparam int CNT_W = $clog2(MUL_CYC);

`ifdef EX_DIVIDER_EN
    typedef enum logic [1:0] {IDLE, MUL, DONE, DIV} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    // mcand: multiplicand (MULT) or divisor (DIVU).
    // work:  {acc, multiplier} for MULT, {remainder, dividend/quotient} for DIVU.
    logic [DATA_W-1:0]   mcand;
    logic [2*DATA_W-1:0] work;

    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [DATA_W-1:0]   store_data;
    logic [DATA_W-1:0]   alu_result;
    logic                is_mult;
    logic                is_div;
    logic                ex_load;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic                last_step;

    logic                unused_rs;
    assign unused_rs = ^rs;

    always_comb begin
        case (fwdA)
            2'b01:   op_a = memWbResult;
            2'b10:   op_a = exMemResult;
            default: op_a = data1;
        endcase
        case (fwdB)
            2'b01:   store_data = memWbResult;
            2'b10:   store_data = exMemResult;
            default: store_data = data2;
        endcase
        op_b = aluSrc ? immediate : store_data;
    end

    always_comb begin
        case (aluOp)
            OP_AND:  alu_result = op_a & op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_XOR:  alu_result = op_a ^ op_b;
            OP_NOR:  alu_result = ~(op_a | op_b);
            OP_ADD:  alu_result = op_a + op_b;
            OP_SUB:  alu_result = op_a - op_b;
            OP_SLT:  alu_result = ($signed(op_a) < $signed(op_b)) ? DATA_W'(1) : '0;
            OP_MFHI: alu_result = hi;
            OP_MFLO: alu_result = lo;
            default: alu_result = '0;
        endcase
    end

    assign is_mult = (aluOp == OP_MULT);
`ifdef EX_DIVIDER_EN
    assign is_div  = (aluOp == OP_DIVU);
`else
    assign is_div  = 1'b0;
`endif

    // Reset masks stall so the pipeline is released in the cycle reset is sampled.
    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    stall = is_mult | is_div;
                MUL:     stall = 1'b1;
`ifdef EX_DIVIDER_EN
                DIV:     stall = 1'b1;
`endif
                default: stall = 1'b0;
            endcase
        end
    end

    // Only an IDLE cycle with a single-cycle op writes real data into EX/MEM.
    assign ex_load = (state == IDLE) && !is_mult && !is_div;

    // Shift-add: add multiplicand to the upper half when the multiplier LSB is set,
    // then shift the whole {acc, multiplier} pair right by one.
    assign mul_sum  = {1'b0, work[2*DATA_W-1:DATA_W]} + {1'b0, (work[0] ? mcand : '0)};
    assign mul_next = {mul_sum, work[DATA_W-1:1]};

    assign last_step = (count == CNT_W'(MUL_CYC - 1));

`ifdef EX_DIVIDER_EN
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] div_next;

    // Restoring step: shift the next dividend bit into the remainder and subtract
    // the divisor if it fits. A zero divisor always "fits", which yields an
    // all-ones quotient and remainder = dividend without any special case.
    assign div_shift = {work[2*DATA_W-1:DATA_W], work[DATA_W-1]};
    assign div_diff  = div_shift - {1'b0, mcand};
    assign div_next  = div_diff[DATA_W]
                     ? {div_shift[DATA_W-1:0], work[DATA_W-2:0], 1'b0}
                     : {div_diff[DATA_W-1:0],  work[DATA_W-2:0], 1'b1};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            work  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mult) begin
                        mcand <= op_a;
                        work  <= {{DATA_W{1'b0}}, op_b};
                        count <= '0;
                        state <= MUL;
                    end
`ifdef EX_DIVIDER_EN
                    else if (is_div) begin
                        mcand <= op_b;
                        work  <= {{DATA_W{1'b0}}, op_a};
                        count <= '0;
                        state <= DIV;
                    end
`endif
                end
                MUL: begin
                    work  <= mul_next;
                    count <= count + 1'b1;
                    if (last_step) begin
                        {hi, lo} <= mul_next;
                        state    <= DONE;
                    end
                end
`ifdef EX_DIVIDER_EN
                DIV: begin
                    work  <= div_next;
                    count <= count + 1'b1;
                    if (last_step) begin
                        {hi, lo} <= div_next;
                        state    <= DONE;
                    end
                end
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !ex_load) begin
            exMemWB        <= '0;
            exMemM         <= '0;
            exMemAluResult <= '0;
            exMemStoreData <= '0;
            exMemWriteReg  <= '0;
            exMemZero      <= 1'b0;
            exMemPcPlus4   <= '0;
        end else begin
            exMemWB        <= WB;
            exMemM         <= M;
            exMemAluResult <= alu_result;
            exMemStoreData <= store_data;
            exMemWriteReg  <= regDst ? rd : rt;
            exMemZero      <= (alu_result == '0);
            exMemPcPlus4   <= pcPlus4;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    logic        clock;
    logic        reset;
    logic [3:0]  aluOp;
    logic        regDst;
    logic        aluSrc;
    logic [1:0]  WB;
    logic [2:0]  M;
    logic [4:0]  rs, rt, rd;
    logic [31:0] pcPlus4, data1, data2, immediate;
    logic [1:0]  fwdA, fwdB;
    logic [31:0] exMemResult, memWbResult;
    logic        stall;
    logic [1:0]  exMemWB;
    logic [2:0]  exMemM;
    logic [31:0] exMemAluResult, exMemStoreData, exMemPcPlus4;
    logic [4:0]  exMemWriteReg;
    logic        exMemZero;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;

    ex_stage dut (
        .clock(clock), .reset(reset), .aluOp(aluOp), .regDst(regDst), .aluSrc(aluSrc),
        .WB(WB), .M(M), .rs(rs), .rt(rt), .rd(rd), .pcPlus4(pcPlus4),
        .data1(data1), .data2(data2), .immediate(immediate),
        .fwdA(fwdA), .fwdB(fwdB), .exMemResult(exMemResult), .memWbResult(memWbResult),
        .stall(stall), .exMemWB(exMemWB), .exMemM(exMemM), .exMemAluResult(exMemAluResult),
        .exMemStoreData(exMemStoreData), .exMemWriteReg(exMemWriteReg),
        .exMemZero(exMemZero), .exMemPcPlus4(exMemPcPlus4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd_sel(input logic [1:0] s, input logic [31:0] rf,
                                            input logic [31:0] ex, input logic [31:0] mw);
        if (s == 2'b01) return mw;
        if (s == 2'b10) return ex;
        return rf;
    endfunction

    function automatic bit is_long(input logic [3:0] op);
`ifdef EX_DIVIDER_EN
        return (op == 4'd8) || (op == 4'd11);
`else
        return (op == 4'd8);
`endif
    endfunction

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd3:  return a ^ b;
            4'd12: return ~(a | b);
            4'd2:  return a + b;
            4'd6:  return a - b;
            4'd7:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9:  return m_hi;
            4'd10: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    task automatic scramble();
        WB = 2'($urandom_range(1, 3)); M = 3'($urandom_range(1, 7));
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
        pcPlus4 = $urandom | 32'h4; data1 = $urandom; data2 = $urandom;
        immediate = $urandom; exMemResult = $urandom; memWbResult = $urandom;
        fwdA = 2'($urandom); fwdB = 2'($urandom); aluSrc = 1'($urandom); regDst = 1'($urandom);
    endtask

    // Applies aluOp with the current operand inputs and checks the whole transaction.
    task automatic do_op(input logic [3:0] op);
        logic [31:0] a, sd, b, res;
        logic [63:0] prod;
        int stalls, bubbles;
        bit done;
        aluOp = op;
        #1;
        a  = fwd_sel(fwdA, data1, exMemResult, memWbResult);
        sd = fwd_sel(fwdB, data2, exMemResult, memWbResult);
        b  = aluSrc ? immediate : sd;
        if (is_long(op)) begin
            stalls = 0; bubbles = 0; done = 0;
            for (int c = 0; c < 40 && !done; c++) begin
                if (stall) stalls++; else done = 1;
                @(posedge clock); #1;
                if (exMemWB == 0 && exMemM == 0 && exMemAluResult == 0 && exMemStoreData == 0 &&
                    exMemWriteReg == 0 && exMemZero == 0 && exMemPcPlus4 == 0)
                    bubbles++;
                scramble();
                aluOp = op;
            end
            chk("long_stall_cycles", 64'(stalls), 64'd33);
            chk("long_bubbles", 64'(bubbles), 64'd34);
            if (op == 4'd8) begin
                prod = 64'(a) * 64'(b);
                m_hi = prod[63:32];
                m_lo = prod[31:0];
            end else if (b == 0) begin
                m_lo = 32'hFFFF_FFFF;
                m_hi = a;
            end else begin
                m_lo = a / b;
                m_hi = a % b;
            end
        end else begin
            res = ref_result(op, a, b);
            chk("single_stall", 64'(stall), 64'd0);
            @(posedge clock); #1;
            chk("wb", 64'(exMemWB), 64'(WB));
            chk("m", 64'(exMemM), 64'(M));
            chk("result", 64'(exMemAluResult), 64'(res));
            chk("store_data", 64'(exMemStoreData), 64'(sd));
            chk("write_reg", 64'(exMemWriteReg), 64'(regDst ? rd : rt));
            chk("zero", 64'(exMemZero), 64'(res == 0));
            chk("pc_plus4", 64'(exMemPcPlus4), 64'(pcPlus4));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, 64'(stall), 64'd0);
        chk({tag, "_wb"}, 64'(exMemWB), 64'd0);
        chk({tag, "_m"}, 64'(exMemM), 64'd0);
        chk({tag, "_result"}, 64'(exMemAluResult), 64'd0);
        chk({tag, "_store"}, 64'(exMemStoreData), 64'd0);
        chk({tag, "_wreg"}, 64'(exMemWriteReg), 64'd0);
        chk({tag, "_zero"}, 64'(exMemZero), 64'd0);
        chk({tag, "_pc"}, 64'(exMemPcPlus4), 64'd0);
    endtask

    logic [3:0] ops [16] = '{4'd0, 4'd1, 4'd3, 4'd12, 4'd2, 4'd6, 4'd7, 4'd9,
                             4'd10, 4'd11, 4'd4, 4'd5, 4'd13, 4'd14, 4'd15, 4'd2};

    initial begin
        reset = 1'b1;
        scramble();
        aluOp = 4'd8;
        repeat (2) @(posedge clock);
        #1;
        // MULT sitting in ID/EX during reset must not stall.
        check_all_zero("reset");

        reset = 1'b0;

        // T1: ADD 7 + 5 into rd 9
        scramble();
        fwdA = 0; fwdB = 0; aluSrc = 0; regDst = 1; rd = 9; data1 = 7; data2 = 5;
        do_op(4'd2);
        chk("t1_result", 64'(exMemAluResult), 64'd12);
        chk("t1_wreg", 64'(exMemWriteReg), 64'd9);
        chk("t1_zero", 64'(exMemZero), 64'd0);

        // T2: SUB with forwarded A = 20 and immediate B = 20
        scramble();
        fwdA = 2'b10; exMemResult = 20; data1 = 99; aluSrc = 1; immediate = 20;
        do_op(4'd6);
        chk("t2_result", 64'(exMemAluResult), 64'd0);
        chk("t2_zero", 64'(exMemZero), 64'd1);

        // T3: signed compare and subtract with -1 and 1
        scramble();
        fwdA = 0; fwdB = 0; aluSrc = 0; data1 = 32'hFFFF_FFFF; data2 = 1;
        do_op(4'd7);
        chk("t3_slt", 64'(exMemAluResult), 64'd1);
        fwdA = 0; fwdB = 0; aluSrc = 0; data1 = 32'hFFFF_FFFF; data2 = 1;
        do_op(4'd6);
        chk("t3_sub", 64'(exMemAluResult), 64'hFFFF_FFFE);

        // T4: MULT 0x10000 * 0x30000, then read back LO and HI
        scramble();
        fwdA = 0; fwdB = 0; aluSrc = 0; data1 = 32'h0001_0000; data2 = 32'h0003_0000;
        do_op(4'd8);
        scramble();
        do_op(4'd10);
        chk("t4_mflo", 64'(exMemAluResult), 64'd0);
        scramble();
        do_op(4'd9);
        chk("t4_mfhi", 64'(exMemAluResult), 64'd3);

        // T5: reset in the middle of a MULT
        scramble();
        fwdA = 0; fwdB = 0; aluSrc = 0; data1 = 32'h1234_5678; data2 = 32'h9ABC_DEF0;
        aluOp = 4'd8;
        @(posedge clock); #1;
        repeat (10) @(posedge clock);
        #1;
        chk("t5_stall_mid", 64'(stall), 64'd1);
        reset = 1'b1;
        #1;
        chk("t5_stall_reset", 64'(stall), 64'd0);
        @(posedge clock); #1;
        check_all_zero("t5_after_reset");
        reset = 1'b0;
        m_hi = 0; m_lo = 0;
        scramble();
        do_op(4'd9);
        scramble();
        do_op(4'd10);
        scramble();
        fwdA = 0; fwdB = 0; aluSrc = 0; data1 = 40; data2 = 2;
        do_op(4'd2);
        chk("t5_add", 64'(exMemAluResult), 64'd42);

`ifdef EX_DIVIDER_EN
        // T6: DIVU 100/7 and 5/0
        scramble();
        fwdA = 0; fwdB = 0; aluSrc = 0; data1 = 100; data2 = 7;
        do_op(4'd11);
        scramble(); do_op(4'd10);
        chk("t6_q", 64'(exMemAluResult), 64'd14);
        scramble(); do_op(4'd9);
        chk("t6_r", 64'(exMemAluResult), 64'd2);
        scramble();
        fwdA = 0; fwdB = 0; aluSrc = 0; data1 = 5; data2 = 0;
        do_op(4'd11);
        scramble(); do_op(4'd10);
        chk("t6_dz_lo", 64'(exMemAluResult), 64'hFFFF_FFFF);
        scramble(); do_op(4'd9);
        chk("t6_dz_hi", 64'(exMemAluResult), 64'd5);
`endif

        // Random mix; multi-cycle ops kept rare to bound run time.
        for (int i = 0; i < 200; i++) begin
            scramble();
            if ($urandom_range(0, 9) == 0) do_op(4'd8);
            else do_op(ops[$urandom_range(0, 15)]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
